// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response bundle between the execute stage and the ALU.
// Latency: none, wires only.
// Backpressure: in_ready qualifies in_valid; out_valid is a one-cycle pulse with no ready.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, zero, hi, lo
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, zero, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered execute-stage ALU; iterative MULTU/DIVU built only with ALU_MULDIV_EN.
// Latency: 1 cycle for single-cycle ops and DIVU by zero; WIDTH+1 cycles for MULTU/DIVU.
// Backpressure: in_ready low while a multiply/divide runs; requests then are ignored, not queued.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_NOR   = 4'b1100;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;

    assign accept        = bus.in_valid && (state_q == IDLE);
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

`ifdef ALU_MULDIV_EN
    // work_hi: accumulator / partial remainder; work_lo: multiplier / dividend-quotient
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] work_hi, work_lo, work_b;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             last_step;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    // One iteration: shift-add multiply (LSB first) or restoring divide (MSB first)
    always_comb begin
        mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, work_b} : '0);
        div_sh   = {work_hi, work_lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, work_b};
        if (state_q == MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_sh[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], 1'b0};
        end
    end
`else
    assign bus.hi = '0;
    assign bus.lo = '0;
`endif

    // Single-cycle ALU result for the presented opcode
    always_comb begin
        alu_res = '0;
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: leave IDLE only for MULTU or DIVU with a nonzero divisor
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef ALU_MULDIV_EN
                if (accept && bus.op == OP_MULTU)
                    state_d = MUL;
                else if (accept && bus.op == OP_DIVU && bus.b != '0)
                    state_d = DIV;
`endif
            end
`ifdef ALU_MULDIV_EN
            MUL, DIV: if (last_step) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, iterate while busy, publish on completion
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            hi_q    <= '0;
            lo_q    <= '0;
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            work_b  <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            if (accept) begin
`ifdef ALU_MULDIV_EN
                if (bus.op == OP_MULTU || (bus.op == OP_DIVU && bus.b != '0)) begin
                    work_hi <= '0;
                    work_lo <= bus.a;
                    work_b  <= bus.b;
                    cnt     <= '0;
                end else if (bus.op == OP_DIVU) begin
                    hi_q        <= bus.a;
                    lo_q        <= '1;
                    result_q    <= '1;
                    zero_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                end else
`endif
                begin
                    result_q    <= alu_res;
                    zero_q      <= (alu_res == '0);
                    out_valid_q <= 1'b1;
                end
            end
`ifdef ALU_MULDIV_EN
            else if (state_q != IDLE) begin
                work_hi <= step_hi;
                work_lo <= step_lo;
                cnt     <= cnt + CNT_W'(1);
                if (last_step) begin
                    hi_q        <= step_hi;
                    lo_q        <= step_lo;
                    result_q    <= step_lo;
                    zero_q      <= (step_lo == '0);
                    out_valid_q <= 1'b1;
                    cnt         <= '0;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors with hand-computed results for alu_muldiv.
// Latency: checks 1-cycle ops and WIDTH+1-cycle MULTU/DIVU completion.
// Backpressure: holds in_valid high while busy to confirm requests are ignored.
module tb_alu_muldiv;
    localparam int W = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_BAD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        tick();
    endtask

    // Called in cycle N+1 of a MULTU/DIVU; returns the cycle offset of out_valid
    task automatic wait_done(output int lat, output int rdy_hi);
        lat    = 1;
        rdy_hi = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_hi++;
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        issue(op, a, b);
        check({tag, "_vld"},  bus.out_valid, 1);
        check({tag, "_res"},  bus.result, exp);
        check({tag, "_zero"}, bus.zero, exp == 0);
    endtask

    initial begin
        int lat, rdy_hi, ov_seen;
        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.a        = '0;
        bus.b        = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_ready",  bus.in_ready, 1);
        check("rst_vld",    bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_zero",   bus.zero, 1);
        check("rst_hi",     bus.hi, 0);
        check("rst_lo",     bus.lo, 0);

        // Back-to-back single-cycle ops, one completion per cycle
        single("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0);
        single("sub",      OP_SUB,  32'd5,         32'd7,          32'hFFFF_FFFE);
        single("slt_neg",  OP_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1);
        single("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0);
        single("slt_min",  OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF,  32'h1);
        single("sltu_lt",  OP_SLTU, 32'h1,         32'hFFFF_FFFF,  32'h1);
        single("bad_op",   OP_BAD,  32'd5,         32'd3,          32'h0);
        single("xor",      OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0);
        single("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000);
        single("nor",      OP_NOR,  32'h0,         32'h0,          32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        tick();
        check("idle_vld",  bus.out_valid, 0);
        check("hold_res",  bus.result, 32'hFFFF_FFFF);
        check("hold_zero", bus.zero, 0);
        check("logic_hi",  bus.hi, 0);
        check("logic_lo",  bus.lo, 0);

`ifdef ALU_MULDIV_EN
        // MULTU with a new request held during busy; it must not be taken
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.op = OP_ADD;
        bus.a  = 32'h1;
        bus.b  = 32'h1;
        wait_done(lat, rdy_hi);
        check("mul_lat",    lat, W + 1);
        check("mul_busy",   rdy_hi, 0);
        check("mul_ready",  bus.in_ready, 1);
        check("mul_hi",     bus.hi, 32'hFFFF_FFFE);
        check("mul_lo",     bus.lo, 32'h0000_0001);
        check("mul_result", bus.result, 32'h1);
        check("mul_zero",   bus.zero, 0);
        tick();
        check("mul_pulse",  bus.out_valid, 0);

        single("add_after", OP_ADD, 32'd2, 32'd3, 32'd5);
        bus.in_valid = 1'b0;
        check("keep_hi", bus.hi, 32'hFFFF_FFFE);
        check("keep_lo", bus.lo, 32'h1);

        issue(OP_MULTU, 32'h1234_5678, 32'h100);
        wait_done(lat, rdy_hi);
        check("mul2_lat", lat, W + 1);
        check("mul2_hi",  bus.hi, 32'h12);
        check("mul2_lo",  bus.lo, 32'h3456_7800);

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(lat, rdy_hi);
        check("div_lat",    lat, W + 1);
        check("div_busy",   rdy_hi, 0);
        check("div_lo",     bus.lo, 32'd14);
        check("div_hi",     bus.hi, 32'd2);
        check("div_result", bus.result, 32'd14);

        issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
        wait_done(lat, rdy_hi);
        check("div2_lo", bus.lo, 32'h0FFF_FFFF);
        check("div2_hi", bus.hi, 32'hF);

        issue(OP_DIVU, 32'd5, 32'd9);
        wait_done(lat, rdy_hi);
        check("div3_lo",   bus.lo, 32'd0);
        check("div3_hi",   bus.hi, 32'd5);
        check("div3_zero", bus.zero, 1);

        issue(OP_DIVU, 32'd9, 32'd0);
        bus.in_valid = 1'b0;
        check("div0_vld",    bus.out_valid, 1);
        check("div0_ready",  bus.in_ready, 1);
        check("div0_lo",     bus.lo, 32'hFFFF_FFFF);
        check("div0_hi",     bus.hi, 32'd9);
        check("div0_result", bus.result, 32'hFFFF_FFFF);
        check("div0_zero",   bus.zero, 0);

        // Reset during the 10th busy cycle of a MULTU abandons it
        issue(OP_MULTU, 32'd3, 32'd5);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_vld",    bus.out_valid, 0);
        check("rmid_ready",  bus.in_ready, 1);
        check("rmid_hi",     bus.hi, 0);
        check("rmid_lo",     bus.lo, 0);
        check("rmid_result", bus.result, 0);
        check("rmid_zero",   bus.zero, 1);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) ov_seen++;
        end
        check("rmid_no_vld", ov_seen, 0);
        single("add_post_rst", OP_ADD, 32'd2, 32'd3, 32'd5);
        bus.in_valid = 1'b0;
`else
        // Without the mul/div unit the codes decode as unknown single-cycle ops
        single("multu_off", OP_MULTU, 32'd3, 32'd4, 32'd0);
        check("multu_off_ready", bus.in_ready, 1);
        check("multu_off_hi",    bus.hi, 0);
        check("multu_off_lo",    bus.lo, 0);
        single("divu_off",  OP_DIVU, 32'd9, 32'd0, 32'd0);
        check("divu_off_hi", bus.hi, 0);
        check("divu_off_lo", bus.lo, 0);
        bus.in_valid = 1'b0;
        tick();
        check("off_pulse", bus.out_valid, 0);

        single("add_pre_rst", OP_ADD, 32'd2, 32'd3, 32'd5);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_vld",    bus.out_valid, 0);
        check("rst2_result", bus.result, 0);
        check("rst2_zero",   bus.zero, 1);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, registered execute-stage ALU for the 5-stage MIPS pipeline: the next generation of the single-cycle combinational ALU. It adds a WIDTH parameter, a valid/ready handshake, signed and unsigned set-less-than, XOR, and an iterative unsigned multiply/divide unit writing HI/LO. Logic ops return one cycle after acceptance; MULTU/DIVU hold the stage busy for WIDTH cycles.

## Interface
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; equals (state == IDLE).
- op  in  4  operation code (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  one-cycle pulse; result/zero (and hi/lo for MULTU/DIVU) are valid this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  registered (result == 0), for BEQ/BNE.
- hi  out  WIDTH  HI register: product upper half / remainder.
- lo  out  WIDTH  LO register: product lower half / quotient.

## Operation
- Accept = in_valid && in_ready at a rising edge. If in_ready is low, in_valid is ignored; no queuing.
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 1100 NOR.
  - 0111 SLT: signed compare, result 1/0.
  - 1000 SLTU: unsigned compare, result 1/0.
  - 1001 MULTU: {hi,lo} = a*b, unsigned, 2*WIDTH bits.
  - 1010 DIVU: lo = a/b, hi = a%b, unsigned.
  - Any other code: result 0, single-cycle path.
- ADD/SUB wrap modulo 2^WIDTH. No overflow flag and no trap.
- State machine:
  - IDLE: single-cycle ops complete here; MULTU goes to MUL; DIVU goes to DIV, or stays in IDLE if b == 0.
  - MUL and DIV each run for exactly WIDTH cycles, counted by a cnt register of $clog2(WIDTH)+1 bits, then return to IDLE.
- MUL: shift-add, one multiplier bit per cycle (LSB first).
- DIV: restoring division, one quotient bit per cycle (MSB first).
- For MULTU/DIVU, result = lo.
- DIVU with b == 0: single-cycle completion with lo = all ones, hi = a.
- hi/lo change only on MULTU/DIVU completion. Other ops leave them unchanged.
- Operands are captured at acceptance. Later changes on a/b/op have no effect on an in-flight operation.

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, zero 1, hi 0, lo 0, state IDLE, cnt 0.
- Single-cycle op accepted in cycle N: out_valid = 1 in N+1. in_ready stays 1, so throughput is one op per cycle back-to-back.
- MULTU/DIVU accepted in cycle N:
  - in_ready = 0 in cycles N+1..N+WIDTH.
  - out_valid = 1 in cycle N+WIDTH+1, with in_ready = 1 in that same cycle, so a new op may be accepted there.
- out_valid is never high for two cycles from one accept.
- result/zero hold their value until the next completion.
- Reset asserted mid-MUL/DIV: the operation is abandoned, no out_valid, all outputs take reset values at that edge.
- Reset takes priority over a simultaneous accept.

## Configuration
- ALU_MULDIV_EN defined: MULTU/DIVU datapath, MUL/DIV states and hi/lo updates are compiled in, as specified above.
- ALU_MULDIV_EN undefined:
  - 1001/1010 decode as other codes: result 0, one-cycle latency.
  - hi/lo are tied to 0. The state machine never leaves IDLE and in_ready is constant 1.

## Test plan
- Reset, then ADD a=0xFFFFFFFF b=1 -> next cycle out_valid=1, result=0, zero=1; SUB 5-7 -> 0xFFFFFFFE, zero=0.
- SLT a=0xFFFFFFFF b=1 -> result 1. SLTU with the same operands -> result 0. NOR 0,0 -> 0xFFFFFFFF. Issue these back-to-back and check one out_valid per cycle.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> in_ready low for 32 cycles, out_valid in cycle N+33 with hi=0xFFFFFFFE, lo=0x00000001, result=1. in_valid held high during busy is not accepted.
- DIVU 100/7 -> lo=14, hi=2 after 33 cycles. DIVU 9/0 -> next cycle lo=0xFFFFFFFF, hi=9.
- Reset asserted at cycle 10 of a MULTU -> no out_valid, hi=lo=0, in_ready=1 the next cycle. A new ADD completes normally.
- Build without ALU_MULDIV_EN: MULTU 3*4 -> out_valid next cycle, result=0, hi=lo=0.
